// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampling UART receive block, LSB-first frames, sticky framing error
//
// Ports:
//   i_CLK            system clock, all flops on its rising edge
//   i_RESET_N        asynchronous active-low reset
//   i_CLK_ENABLE     oversample tick, OVERSAMPLE ticks per bit period
//   i_RX             asynchronous serial line, idles high
//   o_DATA_OUT       last correctly framed word, held until the next good frame
//   o_DATA_VALID     one-cycle strobe when o_DATA_OUT is updated
//   o_RX_BUSY        high whenever the receiver is not idle
//   o_FRAMING_ERROR  sticky; set on a zero stop bit, cleared by the next good frame
module uart_receiver #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 i_CLK,
    input  logic                 i_RESET_N,
    input  logic                 i_CLK_ENABLE,
    input  logic                 i_RX,
    output logic [DATA_BITS-1:0] o_DATA_OUT,
    output logic                 o_DATA_VALID,
    output logic                 o_RX_BUSY,
    output logic                 o_FRAMING_ERROR
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] CNT_MID  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_s;
    logic                 rx_prev;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;

    logic                 start_edge;
    logic                 cnt_clear;
    logic                 take_bit;
    logic                 load_out;
    logic                 set_err;

    // Two-flop synchronizer runs every clock, independent of the tick.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX;
            rx_s    <= rx_meta;
        end
    end

    // A start needs a 1 followed by a 0 on consecutive ticks, so a held-low
    // line (break) cannot retrigger after a frame ends.
    assign start_edge = !rx_s && rx_prev;

    // State register
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        if (i_CLK_ENABLE) begin
            case (state)
                IDLE:    if (start_edge) state_next = START;
                START:   if (cnt == CNT_MID) state_next = rx_s ? IDLE : DATA;
                DATA:    if (cnt == CNT_END && idx == IDX_LAST) state_next = STOP;
                STOP:    if (cnt == CNT_END) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output / datapath-control decode
    always_comb begin
        cnt_clear = 1'b0;
        take_bit  = 1'b0;
        load_out  = 1'b0;
        set_err   = 1'b0;
        o_RX_BUSY = (state != IDLE);
        if (i_CLK_ENABLE) begin
            case (state)
                IDLE:  cnt_clear = start_edge;
                // Re-centres the counter on the start-bit midpoint so every
                // later sample lands mid-bit.
                START: cnt_clear = (cnt == CNT_MID);
                DATA:  take_bit  = (cnt == CNT_END);
                STOP: begin
                    load_out = (cnt == CNT_END) && rx_s;
                    set_err  = (cnt == CNT_END) && !rx_s;
                end
                default: ;
            endcase
        end
    end

    // Tick-gated datapath: counter, bit index, shift register, edge register.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            rx_prev <= 1'b1;
        end else if (i_CLK_ENABLE) begin
            rx_prev <= rx_s;
            if (cnt_clear) begin
                cnt <= '0;
                idx <= '0;
            end else if (state != IDLE) begin
                // Explicit wrap keeps non-power-of-two OVERSAMPLE correct.
                cnt <= (cnt == CNT_END) ? '0 : cnt + 1'b1;
            end
            if (take_bit) begin
                shreg[idx] <= rx_s;
                idx        <= idx + 1'b1;
            end
        end
    end

    // Registered outputs. load_out is already tick-qualified, so the valid
    // strobe is one clock wide whatever the tick rate.
    always_ff @(posedge i_CLK or negedge i_RESET_N) begin
        if (!i_RESET_N) begin
            o_DATA_OUT      <= '0;
            o_DATA_VALID    <= 1'b0;
            o_FRAMING_ERROR <= 1'b0;
        end else begin
            o_DATA_VALID <= load_out;
            if (load_out) begin
                o_DATA_OUT      <= shreg;
                o_FRAMING_ERROR <= 1'b0;
            end else if (set_err) begin
                o_FRAMING_ERROR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - scoreboard bench for uart_receiver
module tb_uart_receiver;

    logic       i_CLK;
    logic       i_RESET_N;
    logic       i_CLK_ENABLE;
    logic       i_RX;
    logic [7:0] o_DATA_OUT;
    logic       o_DATA_VALID;
    logic       o_RX_BUSY;
    logic       o_FRAMING_ERROR;

    uart_receiver #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .i_CLK           (i_CLK),
        .i_RESET_N       (i_RESET_N),
        .i_CLK_ENABLE    (i_CLK_ENABLE),
        .i_RX            (i_RX),
        .o_DATA_OUT      (o_DATA_OUT),
        .o_DATA_VALID    (o_DATA_VALID),
        .o_RX_BUSY       (o_RX_BUSY),
        .o_FRAMING_ERROR (o_FRAMING_ERROR)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    int         n_compared = 0;
    int         n_mismatch = 0;
    logic [7:0] sb[$];

    int cyc        = 0;
    int tick_div   = 1;
    int tick_cnt   = 0;
    int fall_cyc   = 0;
    bit chk_lat    = 1'b0;
    int n_valid    = 0;
    int busy_rises = 0;
    int busy_start = 0;
    int busy_len   = 0;
    logic prev_valid = 1'b0;
    logic prev_busy  = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(posedge i_CLK) cyc++;

    // Tick generator: one enable every tick_div clocks.
    always @(negedge i_CLK) begin
        if (tick_div <= 1) begin
            i_CLK_ENABLE = 1'b1;
            tick_cnt     = 0;
        end else begin
            i_CLK_ENABLE = (tick_cnt == 0);
            tick_cnt     = (tick_cnt + 1) % tick_div;
        end
    end

    // Output monitor: pops the scoreboard on each valid strobe.
    always @(negedge i_CLK) begin
        if (o_DATA_VALID) begin
            n_valid++;
            check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_valid", {23'd0, 1'b0, o_DATA_OUT}, 32'h100);
            end else begin
                check("rx_data", {24'd0, o_DATA_OUT}, {24'd0, sb.pop_front()});
            end
            if (chk_lat) begin
                check("latency_155_pm1", {31'd0, ((cyc - fall_cyc) >= 154) && ((cyc - fall_cyc) <= 156)}, 32'd1);
            end
        end
        if (o_RX_BUSY && !prev_busy) begin
            busy_rises++;
            busy_start = cyc;
        end
        if (!o_RX_BUSY && prev_busy) busy_len = cyc - busy_start;
        prev_valid = o_DATA_VALID;
        prev_busy  = o_RX_BUSY;
    end

    task automatic drive_bit(input logic b, input int n);
        i_RX = b;
        repeat (n) @(negedge i_CLK);
    endtask

    task automatic idle_bits(input int nbits);
        drive_bit(1'b1, nbits * 16 * tick_div);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        int bc;
        bc = 16 * tick_div;
        if (stop_bit) sb.push_back(d);
        fall_cyc = cyc;
        drive_bit(1'b0, bc);
        for (int i = 0; i < 8; i++) drive_bit(d[i], bc);
        drive_bit(stop_bit, bc);
    endtask

    int         r0;
    int         v0;
    logic [7:0] rst_frame;

    initial begin
        i_RESET_N = 1'b0;
        i_RX      = 1'b1;
        repeat (3) @(negedge i_CLK);
        check("reset_data",  {24'd0, o_DATA_OUT}, 32'd0);
        check("reset_valid", {31'd0, o_DATA_VALID}, 32'd0);
        check("reset_busy",  {31'd0, o_RX_BUSY}, 32'd0);
        check("reset_ferr",  {31'd0, o_FRAMING_ERROR}, 32'd0);
        i_RESET_N = 1'b1;
        repeat (5) @(negedge i_CLK);

        // Nominal frame
        chk_lat = 1'b1;
        send_frame(8'h28, 1'b1);
        idle_bits(1);
        chk_lat = 1'b0;
        check("nom_busy_len", busy_len, 152);
        check("nom_valid_cnt", n_valid, 1);
        check("nom_data", {24'd0, o_DATA_OUT}, 32'h28);
        check("nom_ferr", {31'd0, o_FRAMING_ERROR}, 32'd0);

        // Glitch rejection
        r0 = busy_rises;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        check("glitch_busy_rise", busy_rises - r0, 1);
        check("glitch_busy_len", busy_len, 8);
        check("glitch_valid_cnt", n_valid, 1);
        check("glitch_data", {24'd0, o_DATA_OUT}, 32'h28);

        // Framing error and recovery
        send_frame(8'h55, 1'b0);
        check("ferr_set", {31'd0, o_FRAMING_ERROR}, 32'd1);
        check("ferr_data_held", {24'd0, o_DATA_OUT}, 32'h28);
        check("ferr_valid_cnt", n_valid, 1);
        idle_bits(1);
        send_frame(8'hA5, 1'b1);
        idle_bits(1);
        check("recover_ferr", {31'd0, o_FRAMING_ERROR}, 32'd0);
        check("recover_data", {24'd0, o_DATA_OUT}, 32'hA5);

        // Break after an error frame
        send_frame(8'h00, 1'b0);
        r0 = busy_rises;
        drive_bit(1'b0, 20 * 16);
        check("break_no_start", busy_rises - r0, 0);
        check("break_ferr", {31'd0, o_FRAMING_ERROR}, 32'd1);
        idle_bits(2);
        send_frame(8'h3C, 1'b1);
        idle_bits(1);
        check("break_recover_data", {24'd0, o_DATA_OUT}, 32'h3C);
        check("break_recover_ferr", {31'd0, o_FRAMING_ERROR}, 32'd0);

        // Back-to-back frames with a tick every third clock
        tick_div = 3;
        idle_bits(2);
        v0 = n_valid;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(2);
        check("b2b_valid_cnt", n_valid - v0, 2);
        check("b2b_data", {24'd0, o_DATA_OUT}, 32'hFF);

        // Reset in data bit 4, held until the stop bit drives the line high
        tick_div = 1;
        idle_bits(2);
        rst_frame = 8'h81;
        v0 = n_valid;
        drive_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) drive_bit(rst_frame[i], 16);
        drive_bit(rst_frame[4], 8);
        check("pre_reset_busy", {31'd0, o_RX_BUSY}, 32'd1);
        i_RESET_N = 1'b0;
        #1;
        check("midrst_data",  {24'd0, o_DATA_OUT}, 32'd0);
        check("midrst_valid", {31'd0, o_DATA_VALID}, 32'd0);
        check("midrst_busy",  {31'd0, o_RX_BUSY}, 32'd0);
        check("midrst_ferr",  {31'd0, o_FRAMING_ERROR}, 32'd0);
        repeat (8) @(negedge i_CLK);
        for (int i = 5; i < 8; i++) drive_bit(rst_frame[i], 16);
        drive_bit(1'b1, 8);
        i_RESET_N = 1'b1;
        drive_bit(1'b1, 8);
        r0 = busy_rises;
        idle_bits(2);
        check("postrst_no_start", busy_rises - r0, 0);
        check("postrst_no_valid", n_valid - v0, 0);
        check("postrst_data", {24'd0, o_DATA_OUT}, 32'd0);
        send_frame(8'h7E, 1'b1);
        idle_bits(1);
        check("postrst_frame", {24'd0, o_DATA_OUT}, 32'h7E);
        check("postrst_valid_cnt", n_valid - v0, 1);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive block: the receiving end of the link driven by `uart_transmitter`. It oversamples the asynchronous serial line on a shared baud-rate enable and locates each frame's start bit. Each bit is sampled at its midpoint and assembled LSB first. The block presents each completed byte with a one-cycle valid strobe and a sticky framing-error flag.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: enable ticks per bit period. Must be even and ≥ 4. Counter width is clog2(OVERSAMPLE).
- `DATA_BITS`, default 8: data bits per frame, legal range 5–9.

Ports:
- `i_CLK`, input, 1: single system clock. All flops are on its rising edge.
- `i_RESET_N`, input, 1: asynchronous, active-low reset.
- `i_CLK_ENABLE`, input, 1: oversample tick, asserted for one `i_CLK` cycle, OVERSAMPLE times per bit period.
- `i_RX`, input, 1: asynchronous serial line. Idles high. Frame is 1 start bit (0), DATA_BITS data bits LSB first, and 1 stop bit (1). No parity.
- `o_DATA_OUT`, output, DATA_BITS: last correctly framed word. Holds until the next good frame.
- `o_DATA_VALID`, output, 1: one-cycle pulse when `o_DATA_OUT` is updated.
- `o_RX_BUSY`, output, 1: high while a frame is being received (any state other than IDLE).
- `o_FRAMING_ERROR`, output, 1: sticky. Set when a stop bit is sampled as 0.

## Operation
- **Synchronizer.** `i_RX` passes through a 2-flop synchronizer clocked every `i_CLK`; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- **Edge register.** `rx_prev` updates to `rx_s` on each tick and resets to 1.
- **IDLE.**
  - On a tick with `rx_s`=0 and `rx_prev`=1, clear the tick counter and go to START.
  - A line held low (break) never re-triggers; a 1 must be seen first.
- **START.**
  - Increment the counter each tick.
  - On the tick where the counter equals OVERSAMPLE/2−1 (midpoint of the start bit):
    - if `rx_s`=0: clear the counter and bit index, go to DATA;
    - else: treat as a glitch and return to IDLE with no output change.
- **DATA.**
  - Increment the counter each tick.
  - On the tick where the counter equals OVERSAMPLE−1: shift `rx_s` into bit [index] of the shift register, wrap the counter to 0, and increment the index.
  - After bit DATA_BITS−1 is taken, go to STOP.
- **STOP.** On the tick where the counter equals OVERSAMPLE−1, sample `rx_s`, then go to IDLE.
  - `rx_s`=1: load `o_DATA_OUT` from the shift register, pulse `o_DATA_VALID`, clear `o_FRAMING_ERROR`.
  - `rx_s`=0: set `o_FRAMING_ERROR`. `o_DATA_OUT` is unchanged and there is no valid pulse.
- **Enable gating.** With `i_CLK_ENABLE` low, the FSM, counter, shift register and `rx_prev` all hold. Only the synchronizer runs.
- **Reset.** Asserting `i_RESET_N` low at any time, including mid-frame, immediately forces:
  - IDLE, with counter, index and shift register at 0;
  - synchronizer flops and `rx_prev` at 1;
  - all four outputs at 0.
  The next frame needs a fresh 1→0 edge after reset is released.

## Timing
- Reset values: `o_DATA_OUT`=0, `o_DATA_VALID`=0, `o_RX_BUSY`=0, `o_FRAMING_ERROR`=0.
- Input to decision: 2 `i_CLK` cycles of synchronizer delay, plus up to one tick period until the next tick.
- Start midpoint: OVERSAMPLE/2 ticks after the edge-detect tick. Data bit n is sampled (n+1)·OVERSAMPLE ticks after the midpoint; the stop bit follows at (DATA_BITS+1)·OVERSAMPLE.
  - Defaults: 8 ticks to the midpoint and 152 ticks from edge detect to the stop sample.
- `o_DATA_VALID` and the `o_DATA_OUT` update are registered. Both appear in the `i_CLK` cycle after the stop-sample tick.
  - `o_DATA_VALID` lasts exactly 1 cycle, regardless of the tick rate.
- `o_FRAMING_ERROR` changes in the same cycle that `o_DATA_VALID` would have been asserted.
- `o_RX_BUSY` rises in the cycle after the edge-detect tick and falls in the cycle after the stop-sample or glitch-reject tick.
- Back-to-back frames:
  - the stop sample lands at the stop-bit midpoint and the FSM is in IDLE from the next cycle;
  - a start edge half a bit later is accepted;
  - no idle gap is required beyond one stop bit.
- Tolerance: baud mismatch up to ±(OVERSAMPLE/2−1)/OVERSAMPLE of one bit, accumulated over a frame, is sampled correctly.

## Test plan
- **Nominal frame.** OVERSAMPLE=16, tick every cycle. Frame 0x28 at 16 cycles per bit → `o_DATA_OUT`=0x28 and one valid pulse, 2+152+1 cycles after the line falls (±1); `o_FRAMING_ERROR`=0; `o_RX_BUSY` high throughout.
- **Glitch rejection.** `i_RX` low for 4 ticks, then high → no valid pulse, `o_DATA_OUT` unchanged, `o_RX_BUSY` drops 8 ticks after rising.
- **Framing error and recovery.** Frame 0x55 with stop bit 0 → `o_FRAMING_ERROR`=1, no valid pulse, `o_DATA_OUT` still 0x28. Then line high for 1 bit and frame 0xA5 → `o_DATA_OUT`=0xA5, valid pulse, `o_FRAMING_ERROR`=0.
- **Break.** Line held low for 20 bit times after an error frame → no further start is detected. Line returns high, then frame 0x3C → 0x3C received.
- **Back-to-back plus gating.** Frames 0x00 then 0xFF with a 1-bit stop only, ticks every 3rd cycle (48 cycles per bit) → two valid pulses of 1 cycle each, data 0x00 then 0xFF.
- **Reset mid-frame.** `i_RESET_N` pulsed low during data bit 4 of 0x81 → all outputs 0 immediately. The rest of the frame produces no output until the line idles high and a new frame 0x7E arrives, which is received as 0x7E.
